mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates occur on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- op  in  6  instr[31:26], taken from the IR register.
- funct  in  6  instr[5:0], taken from the IR register.
- zero  in  1  ALU equality flag, valid in EXEC.
- pc_wr  out  1  PC register write enable.
- ir_wr  out  1  IR register write enable.
- rf_wr  out  1  register file write enable.
- dm_wr  out  1  data memory write enable.
- npc_sel  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 rs.
- reg_dst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- wd_sel  out  2  write-data select: 00 ALU result, 01 memory data, 10 PC+4.
- alu_src  out  1  ALU operand B select: 0 rt, 1 extended immediate.
- ext_op  out  1  immediate extension: 0 zero-extend, 1 sign-extend.
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 or, 11 imm<<16.
- state  out  3  current FSM state, for debug.

Function
REQ-002 The FSM SHALL have five states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 SHALL go to FETCH on the next edge.
REQ-003 Instruction set, decoded from op and funct:
- addu: op 0, funct 0x21.
- subu: op 0, funct 0x23.
- jr: op 0, funct 0x08.
- ori: op 0x0D.
- lui: op 0x0F.
- lw: op 0x23.
- sw: op 0x2B.
- beq: op 0x04.
- j: op 0x02.
- jal: op 0x03.
REQ-004 Any other op/funct combination SHALL be treated as a nop: path FETCH->DECODE->FETCH, with no write enables asserted in DECODE.
REQ-005 FETCH SHALL assert ir_wr=1, pc_wr=1 and npc_sel=00, then go to DECODE unconditionally.
REQ-006 DECODE transitions:
- j: assert pc_wr, npc_sel=10; go to FETCH.
- jal: assert pc_wr, npc_sel=10, rf_wr, reg_dst=10, wd_sel=10; go to FETCH.
- jr: assert pc_wr, npc_sel=11; go to FETCH.
- All other instructions: go to EXEC.
REQ-007 EXEC ALU setup:
- addu: alu_op=00, alu_src=0.
- subu: alu_op=01, alu_src=0.
- ori: alu_op=10, alu_src=1, ext_op=0.
- lui: alu_op=11, alu_src=1.
- lw/sw: alu_op=00, alu_src=1, ext_op=1.
- beq: alu_op=01, alu_src=0, ext_op=1.
REQ-008 EXEC transitions:
- beq: assert pc_wr only if zero=1, with npc_sel=01; go to FETCH.
- lw/sw: go to MEM.
- addu/subu/ori/lui: go to WB.
REQ-009 MEM transitions:
- sw: assert dm_wr; go to FETCH.
- lw: assert no enables; go to WB.
REQ-010 WB SHALL assert rf_wr, then go to FETCH.
- R-type: reg_dst=01, wd_sel=00.
- ori/lui: reg_dst=00, wd_sel=00.
- lw: reg_dst=00, wd_sel=01.
REQ-011 All outputs SHALL be combinational functions of the state register and the decoded op/funct (Moore-style decode). pc_wr in EXEC additionally depends on zero.
REQ-012 The four write enables (pc_wr, ir_wr, rf_wr, dm_wr) SHALL be 0 in every state/instruction pair not listed above. Select fields SHALL be 0 when unused.
REQ-013 Per-instruction latency in cycles:
- addu/subu/ori/lui: 4.
- lw: 5.
- sw: 4.
- beq: 3.
- j/jal/jr/nop: 2.

Reset
REQ-014 When reset=1 at a rising edge, state SHALL become FETCH. This applies in any state, including mid-instruction, and any pending MEM/WB write is abandoned.
REQ-015 While reset=1, all four write enables SHALL be forced to 0, overriding FETCH decode. The first fetch SHALL occur on the first edge after reset falls.

Configuration
REQ-016 Macro MC_CTRL_PERF_CNT_EN: when defined, the block SHALL add two output ports.
- cyc_cnt (32-bit): increments every non-reset cycle.
- ret_cnt (32-bit): increments on every transition into FETCH from any non-FETCH state.
- Both counters SHALL clear to 0 on reset and wrap modulo 2^32.
REQ-017 When MC_CTRL_PERF_CNT_EN is undefined, neither counter port nor its logic SHALL exist. FSM behaviour SHALL be identical with and without the macro.

Verification
REQ-018 Reset for 2 cycles, then op=0x0F (lui): state sequence 0,1,2,4,0; rf_wr=1 only in WB, with reg_dst=00 and alu_op=11.
REQ-019 op=0x23 (lw): states 0,1,2,3,4; WB shows wd_sel=01 and rf_wr=1; dm_wr=0 throughout.
REQ-020 op=0x04 (beq): with zero=1, EXEC shows pc_wr=1, npc_sel=01; with zero=0, pc_wr=0 in EXEC; both runs return to FETCH after 3 cycles.
REQ-021 op=0x03 (jal): DECODE shows pc_wr=1, npc_sel=10, rf_wr=1, reg_dst=10, wd_sel=10; next state is FETCH.
REQ-022 op=0x2B (sw) with reset asserted while in MEM: dm_wr=0 that cycle, and state=FETCH on the next edge.
REQ-023 With MC_CTRL_PERF_CNT_EN defined, run addu, sw, j, then an undefined op (0x3F): ret_cnt=4 and cyc_cnt=12 after the final FETCH entry.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Outputs are Moore-style decodes of the state register and the IR opcode
// fields; only pc_wr in EXEC also looks at the ALU zero flag.
// Optional build macro MC_CTRL_PERF_CNT_EN adds cycle/retire counters.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic        rf_wr,
    output logic        dm_wr,
    output logic [1:0]  npc_sel,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic        ext_op,
    output logic [1:0]  alu_op,
    output logic [2:0]  state
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic is_r;
    logic is_addu;
    logic is_subu;
    logic is_jr;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;

    // Instruction decode from the IR opcode/function fields
    always_comb begin
        is_r    = (op == 6'h00);
        is_addu = is_r && (funct == 6'h21);
        is_subu = is_r && (funct == 6'h23);
        is_jr   = is_r && (funct == 6'h08);
        is_ori  = (op == 6'h0D);
        is_lui  = (op == 6'h0F);
        is_lw   = (op == 6'h23);
        is_sw   = (op == 6'h2B);
        is_beq  = (op == 6'h04);
        is_j    = (op == 6'h02);
        is_jal  = (op == 6'h03);
    end

    // State register; reset returns to FETCH from anywhere
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and control decode; undefined encodings fall back to FETCH
    always_comb begin
        nxt_state = S_FETCH;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        rf_wr     = 1'b0;
        dm_wr     = 1'b0;
        npc_sel   = 2'b00;
        reg_dst   = 2'b00;
        wd_sel    = 2'b00;
        alu_src   = 1'b0;
        ext_op    = 1'b0;
        alu_op    = 2'b00;
        case (cur_state)
            S_FETCH: begin
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                nxt_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'b10;
                end else if (is_jal) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'b10;
                    rf_wr   = 1'b1;
                    reg_dst = 2'b10;
                    wd_sel  = 2'b10;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'b11;
                end else if (is_addu || is_subu || is_ori || is_lui ||
                             is_lw || is_sw || is_beq) begin
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_addu) begin
                    nxt_state = S_WB;
                end else if (is_subu) begin
                    alu_op    = 2'b01;
                    nxt_state = S_WB;
                end else if (is_ori) begin
                    alu_op    = 2'b10;
                    alu_src   = 1'b1;
                    nxt_state = S_WB;
                end else if (is_lui) begin
                    alu_op    = 2'b11;
                    alu_src   = 1'b1;
                    nxt_state = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src   = 1'b1;
                    ext_op    = 1'b1;
                    nxt_state = S_MEM;
                end else if (is_beq) begin
                    alu_op    = 2'b01;
                    ext_op    = 1'b1;
                    npc_sel   = 2'b01;
                    pc_wr     = zero;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    dm_wr = 1'b1;
                end else if (is_lw) begin
                    nxt_state = S_WB;
                end
            end
            S_WB: begin
                rf_wr = 1'b1;
                if (is_r) begin
                    reg_dst = 2'b01;
                end
                if (is_lw) begin
                    wd_sel = 2'b01;
                end
            end
            default: nxt_state = S_FETCH;
        endcase
        // Reset suppresses every write, including the FETCH writes
        if (reset) begin
            pc_wr = 1'b0;
            ir_wr = 1'b0;
            rf_wr = 1'b0;
            dm_wr = 1'b0;
        end
    end

    assign state = STATE_W'(cur_state);

`ifdef MC_CTRL_PERF_CNT_EN
    // Cycle counter and retire counter (entry into FETCH from elsewhere)
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= 32'd0;
            ret_cnt <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if ((nxt_state == S_FETCH) && (cur_state != S_FETCH)) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Stimulus walks instructions
// step by step and queues the expected control word for every cycle; a
// negedge monitor pops and compares against the DUT outputs.
module tb_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        pc_wr;
    logic        ir_wr;
    logic        rf_wr;
    logic        dm_wr;
    logic [1:0]  npc_sel;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        alu_src;
    logic        ext_op;
    logic [1:0]  alu_op;
    logic [2:0]  state;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
    int unsigned exp_cyc;
    int unsigned exp_ret;
`endif

    mc_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .funct   (funct),
        .zero    (zero),
        .pc_wr   (pc_wr),
        .ir_wr   (ir_wr),
        .rf_wr   (rf_wr),
        .dm_wr   (dm_wr),
        .npc_sel (npc_sel),
        .reg_dst (reg_dst),
        .wd_sel  (wd_sel),
        .alu_src (alu_src),
        .ext_op  (ext_op),
        .alu_op  (alu_op),
        .state   (state)
`ifdef MC_CTRL_PERF_CNT_EN
        ,
        .cyc_cnt (cyc_cnt),
        .ret_cnt (ret_cnt)
`endif
    );

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW,
                      K_BEQ, K_J, K_JAL, K_NOP} kind_t;

    // Expected word: {state[2:0], pc_wr, ir_wr, rf_wr, dm_wr,
    //                 npc_sel[1:0], reg_dst[1:0], wd_sel[1:0],
    //                 alu_src, ext_op, alu_op[1:0]}
    logic [16:0] exp_q[$];
    string       name_q[$];
    int          tests;
    int          fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00 && f == 6'h21) return K_ADDU;
        if (o == 6'h00 && f == 6'h23) return K_SUBU;
        if (o == 6'h00 && f == 6'h08) return K_JR;
        if (o == 6'h0D) return K_ORI;
        if (o == 6'h0F) return K_LUI;
        if (o == 6'h23) return K_LW;
        if (o == 6'h2B) return K_SW;
        if (o == 6'h04) return K_BEQ;
        if (o == 6'h02) return K_J;
        if (o == 6'h03) return K_JAL;
        return K_NOP;
    endfunction

    // Cycles from FETCH back to FETCH for each instruction class
    function automatic int latency(input kind_t k);
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: return 4;
            K_LW:  return 5;
            K_SW:  return 4;
            K_BEQ: return 3;
            default: return 2;
        endcase
    endfunction

    // Control word the instruction should show at cycle s of its run
    function automatic logic [16:0] expect_at(input kind_t k, input int s, input logic z);
        logic [2:0] st;
        logic       pc, ir, rf, dm, asrc, ext;
        logic [1:0] npc, rd, wd, aop;
        pc = 0; ir = 0; rf = 0; dm = 0; asrc = 0; ext = 0;
        npc = 0; rd = 0; wd = 0; aop = 0;
        if (s <= 2)      st = 3'(s);
        else if (s == 3) st = (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
        else             st = 3'd4;
        if (st == 3'd0) begin
            pc = 1; ir = 1;
        end else if (st == 3'd1) begin
            if (k == K_J)   begin pc = 1; npc = 2'b10; end
            if (k == K_JAL) begin pc = 1; npc = 2'b10; rf = 1; rd = 2'b10; wd = 2'b10; end
            if (k == K_JR)  begin pc = 1; npc = 2'b11; end
        end else if (st == 3'd2) begin
            if (k == K_SUBU) aop = 2'b01;
            if (k == K_ORI)  begin aop = 2'b10; asrc = 1; end
            if (k == K_LUI)  begin aop = 2'b11; asrc = 1; end
            if (k == K_LW || k == K_SW) begin asrc = 1; ext = 1; end
            if (k == K_BEQ)  begin aop = 2'b01; ext = 1; npc = 2'b01; pc = z; end
        end else if (st == 3'd3) begin
            if (k == K_SW) dm = 1;
        end else begin
            rf = 1;
            if (k == K_ADDU || k == K_SUBU) rd = 2'b01;
            if (k == K_LW) wd = 2'b01;
        end
        return {st, pc, ir, rf, dm, npc, rd, wd, asrc, ext, aop};
    endfunction

    // Monitor: one expected word per cycle, checked mid-cycle
    always @(negedge clk) begin
        logic [16:0] got;
        logic [16:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got = {state, pc_wr, ir_wr, rf_wr, dm_wr, npc_sel, reg_dst,
                   wd_sel, alu_src, ext_op, alu_op};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL %s: got %05h required %05h", nm, got, e);
            end
        end
    end

    // Run one instruction; abort_at >= 0 raises reset at that step
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int abort_at, input string nm);
        kind_t       k;
        int          lat;
        logic [16:0] e;
        k   = classify(o, f);
        lat = latency(k);
        op    = o;
        funct = f;
        for (int s = 0; s < lat; s++) begin
            zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            reset = (s == abort_at);
            e = expect_at(k, s, zero);
            if (reset) e[13:10] = 4'b0000;
            exp_q.push_back(e);
            name_q.push_back($sformatf("%s step%0d", nm, s));
            @(posedge clk);
            #1;
`ifdef MC_CTRL_PERF_CNT_EN
            if (reset) begin
                exp_cyc = 0;
                exp_ret = 0;
            end else begin
                exp_cyc++;
                if (s == lat - 1) exp_ret++;
            end
`endif
            if (reset) break;
        end
        reset = 1'b0;
`ifdef MC_CTRL_PERF_CNT_EN
        tests++;
        if (cyc_cnt !== exp_cyc || ret_cnt !== exp_ret) begin
            fails++;
            $display("FAIL %s counters: got cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                     nm, cyc_cnt, ret_cnt, exp_cyc, exp_ret);
        end
`endif
    endtask

    logic [5:0] vop [10];
    logic [5:0] vfn [10];

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;
`ifdef MC_CTRL_PERF_CNT_EN
        exp_cyc = 0;
        exp_ret = 0;
`endif
        vop = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
        vfn = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

        // Two reset cycles: FETCH with all write enables held low
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(17'h0);
            name_q.push_back($sformatf("reset cycle%0d", i));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        // Directed sequences
        run_instr(6'h0F, 6'h00, 0, -1, "lui");
        run_instr(6'h23, 6'h00, 0, -1, "lw");
        run_instr(6'h04, 6'h00, 1, -1, "beq_taken");
        run_instr(6'h04, 6'h00, 0, -1, "beq_not_taken");
        run_instr(6'h03, 6'h00, 0, -1, "jal");
        run_instr(6'h00, 6'h08, 0, -1, "jr");
        run_instr(6'h2B, 6'h00, 0, 3, "sw_reset_in_mem");
        run_instr(6'h00, 6'h00, 0, -1, "nop_sll");
        run_instr(6'h0F, 6'h00, 0, 3, "lui_reset_in_wb");

        // Counter scenario: reset, then addu, sw, j, undefined op
        run_instr(6'h3F, 6'h00, 0, 0, "reset_pulse");
        run_instr(6'h00, 6'h21, 0, -1, "addu");
        run_instr(6'h2B, 6'h00, 0, -1, "sw");
        run_instr(6'h02, 6'h00, 0, -1, "j");
        run_instr(6'h3F, 6'h00, 0, -1, "undef_3f");
`ifdef MC_CTRL_PERF_CNT_EN
        tests++;
        if (cyc_cnt !== 32'd12 || ret_cnt !== 32'd4) begin
            fails++;
            $display("FAIL perf_seq: got cyc=%0d ret=%0d required cyc=12 ret=4",
                     cyc_cnt, ret_cnt);
        end
`endif

        // Randomized instruction stream with occasional mid-instruction reset
        for (int n = 0; n < 300; n++) begin
            logic [5:0] o;
            logic [5:0] f;
            int         pick;
            int         ab;
            pick = $urandom_range(0, 12);
            if (pick < 10) begin
                o = vop[pick];
                f = (o == 6'h00) ? vfn[pick] : 6'($urandom_range(0, 63));
            end else begin
                o = 6'($urandom_range(0, 63));
                f = 6'($urandom_range(0, 63));
            end
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(o, f, 2, ab, $sformatf("rnd%0d op%02h fn%02h", n, o, f));
        end

        // Let the monitor drain the scoreboard
        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
